// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray sequence checker: state encoding,
// lock-counter width and the Gray-to-binary decode used by the pipeline.
package gray_pkg;

    localparam int GRAY_MAXW = 32;
    localparam int LOCK_CW   = 4;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FAULT  = 2'd2
    } chk_state_t;

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
        logic [GRAY_MAXW-1:0] b;
        b[GRAY_MAXW-1] = g[GRAY_MAXW-1];
        for (int i = GRAY_MAXW-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_pipe.sv
// Two-stage Gray decode with valid and wrap sideband; o_bin holds the last valid sample.
// Latency 2 cycles, no backpressure: a sample is accepted on every cycle it is valid.
module gray2bin_pipe
    import gray_pkg::*;
#(
    parameter int CBITS = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CBITS-1:0] i_gray,
    input  logic             i_vld,
    input  logic             i_wrap,
    output logic [CBITS-1:0] o_bin,
    output logic             o_vld,
    output logic             o_wrap
);

    logic [CBITS-1:0] r_gray1;
    logic             r_vld1;
    logic             r_wrap1;
    logic [CBITS-1:0] r_bin2;
    logic             r_vld2;
    logic             r_wrap2;
    logic [CBITS-1:0] w_bin1;

    assign w_bin1 = CBITS'(gray2bin(GRAY_MAXW'(r_gray1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gray1 <= '0;
            r_vld1  <= 1'b0;
            r_wrap1 <= 1'b0;
            r_bin2  <= '0;
            r_vld2  <= 1'b0;
            r_wrap2 <= 1'b0;
        end else begin
            r_gray1 <= i_gray;
            r_vld1  <= i_vld;
            r_wrap1 <= i_wrap;
            r_vld2  <= r_vld1;
            r_wrap2 <= r_wrap1;
            if (r_vld1) begin
                r_bin2 <= w_bin1;
            end
        end
    end

    assign o_bin  = r_bin2;
    assign o_vld  = r_vld2;
    assign o_wrap = r_wrap2;

endmodule

// File: rtl/gray_seq_checker.sv
// Checks that decoded Gray samples advance by exactly +1 and that wrap pulses line up
// with the all-ones sample; status is 2 cycles behind the input, no backpressure.
module gray_seq_checker
    import gray_pkg::*;
#(
    parameter int CBITS  = 14,
    parameter int LOCK_N = 4,
    parameter int WBITS  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CBITS-1:0] gray_in,
    input  logic             gray_vld,
    input  logic             wrap_in,
    input  logic             clr_err,
    output logic [CBITS-1:0] bin_out,
    output logic             bin_vld,
    output logic             locked,
    output logic             step_err,
    output logic             fault,
    output logic [WBITS-1:0] wrap_cnt
);

    logic [CBITS-1:0]   w_bin;
    logic               w_vld;
    logic               w_wrap;

    chk_state_t         r_state;
    chk_state_t         w_state_nxt;
    logic [CBITS-1:0]   r_prev;
    logic               r_prev_vld;
    logic [LOCK_CW-1:0] r_good_cnt;
    logic [WBITS-1:0]   r_wrap_cnt;

    logic [CBITS-1:0]   w_prev_inc;
    logic               w_step_ok;
    logic               w_wrap_ok;
    logic [LOCK_CW-1:0] w_good_nxt;
    logic               w_prev_upd;
    logic               w_prev_clr;
    logic               w_wrap_inc;
    logic               w_step_err;

    gray2bin_pipe #(
        .CBITS (CBITS)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_gray (gray_in),
        .i_vld  (gray_vld),
        .i_wrap (wrap_in),
        .o_bin  (w_bin),
        .o_vld  (w_vld),
        .o_wrap (w_wrap)
    );

    // The upstream register lags its counter, so the wrap pulse rides with the all-ones sample.
    assign w_prev_inc = r_prev + CBITS'(1);
    assign w_step_ok  = r_prev_vld && (w_bin == w_prev_inc);
    assign w_wrap_ok  = (w_wrap == (&w_bin));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_prev_upd  = 1'b0;
        w_prev_clr  = 1'b0;
        w_wrap_inc  = 1'b0;
        w_step_err  = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (w_vld) begin
                    w_prev_upd = 1'b1;
                    if (r_prev_vld) begin
                        if (w_step_ok && w_wrap_ok) begin
                            if (r_good_cnt == LOCK_CW'(LOCK_N - 1)) begin
                                w_state_nxt = ST_LOCKED;
                                w_good_nxt  = '0;
                            end else begin
                                w_good_nxt = r_good_cnt + LOCK_CW'(1);
                            end
                        end else begin
                            w_good_nxt = '0;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (w_vld) begin
                    if (!w_step_ok || !w_wrap_ok) begin
                        w_state_nxt = ST_FAULT;
                        w_step_err  = 1'b1;
                    end else begin
                        w_prev_upd = 1'b1;
                        w_wrap_inc = w_wrap;
                    end
                end
            end
            ST_FAULT: begin
                if (clr_err) begin
                    w_state_nxt = ST_SYNC;
                    w_good_nxt  = '0;
                    w_prev_clr  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
                w_good_nxt  = '0;
                w_prev_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_good_cnt <= '0;
            r_wrap_cnt <= '0;
        end else begin
            r_good_cnt <= w_good_nxt;
            if (w_prev_upd) begin
                r_prev     <= w_bin;
                r_prev_vld <= 1'b1;
            end else if (w_prev_clr) begin
                r_prev_vld <= 1'b0;
            end
            if (w_wrap_inc && (r_wrap_cnt != '1)) begin
                r_wrap_cnt <= r_wrap_cnt + WBITS'(1);
            end
        end
    end

    assign bin_out  = w_bin;
    assign bin_vld  = w_vld;
    assign locked   = (r_state == ST_LOCKED);
    assign fault    = (r_state == ST_FAULT);
    assign step_err = w_step_err;
    assign wrap_cnt = r_wrap_cnt;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Bench for gray_seq_checker: directed scenarios plus random traffic, every cycle
// compared against a sample-level model of the sequence rules.
module tb_gray_seq_checker;

    localparam int CBITS  = 4;
    localparam int LOCK_N = 4;
    localparam int WBITS  = 2;
    localparam int MOD    = 1 << CBITS;
    localparam int WMAX   = (1 << WBITS) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [CBITS-1:0] gray_in;
    logic             gray_vld;
    logic             wrap_in;
    logic             clr_err;
    logic [CBITS-1:0] bin_out;
    logic             bin_vld;
    logic             locked;
    logic             step_err;
    logic             fault;
    logic [WBITS-1:0] wrap_cnt;

    always #5 clk = ~clk;

    gray_seq_checker #(
        .CBITS  (CBITS),
        .LOCK_N (LOCK_N),
        .WBITS  (WBITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .gray_in  (gray_in),
        .gray_vld (gray_vld),
        .wrap_in  (wrap_in),
        .clr_err  (clr_err),
        .bin_out  (bin_out),
        .bin_vld  (bin_vld),
        .locked   (locked),
        .step_err (step_err),
        .fault    (fault),
        .wrap_cnt (wrap_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: sample history, mode (0 sync, 1 locked, 2 fault), run of good
    // steps, last accepted value (-1 = none), wraps counted, last shown value.
    typedef struct {
        bit v;
        int b;
        bit w;
    } smp_t;

    smp_t hist[$];
    int   m_mode, m_run, m_prev, m_wraps, m_bin;
    int   cyc, first_lock, n_pulse, cur;

    function automatic int decode(input int g);
        int b = 0;
        for (int s = g; s != 0; s = s >> 1) b ^= s;
        return b;
    endfunction

    function automatic bit violates(input smp_t s);
        bit step_ok = (m_prev >= 0) && (s.b == (m_prev + 1) % MOD);
        bit wrap_ok = (s.w == (s.b == MOD - 1));
        return !(step_ok && wrap_ok);
    endfunction

    task automatic model_reset();
        smp_t z = '{v: 1'b0, b: 0, w: 1'b0};
        hist = {};
        hist.push_back(z);
        hist.push_back(z);
        m_mode = 0; m_run = 0; m_prev = -1; m_wraps = 0; m_bin = 0;
    endtask

    task automatic model_edge(input smp_t nin, input bit clr);
        smp_t s   = hist.pop_front();
        bit   bad = s.v && violates(s);
        case (m_mode)
            0: if (s.v) begin
                if (m_prev >= 0) m_run = bad ? 0 : m_run + 1;
                m_prev = s.b;
                if (m_run == LOCK_N) begin m_mode = 1; m_run = 0; end
            end
            1: if (s.v) begin
                if (bad) m_mode = 2;
                else begin
                    m_prev = s.b;
                    if (s.w && m_wraps < WMAX) m_wraps++;
                end
            end
            default: if (clr) begin m_mode = 0; m_run = 0; m_prev = -1; end
        endcase
        hist.push_back(nin);
        if (hist[0].v) m_bin = hist[0].b;
    endtask

    task automatic compare_all();
        check("bin_vld", bin_vld, hist[0].v);
        check("bin_out", bin_out, m_bin);
        check("locked", locked, m_mode == 1);
        check("fault", fault, m_mode == 2);
        check("step_err", step_err, (m_mode == 1) && hist[0].v && violates(hist[0]));
        check("wrap_cnt", wrap_cnt, m_wraps);
    endtask

    // Drive one cycle of input given as a binary value, clock it, then compare.
    task automatic tick(input int b, input bit v, input bit w, input bit c);
        smp_t nin;
        gray_in  = CBITS'(b ^ (b >> 1));
        gray_vld = v;
        wrap_in  = w;
        clr_err  = c;
        nin.v = v;
        nin.b = decode(int'(gray_in));
        nin.w = w;
        @(posedge clk);
        model_edge(nin, c);
        @(negedge clk);
        cyc++;
        if (locked && first_lock < 0) first_lock = cyc;
        if (step_err) n_pulse++;
        compare_all();
    endtask

    task automatic feed(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick(cur, 1'b1, cur == MOD - 1, 1'b0);
            cur = (cur + 1) % MOD;
            for (int j = 0; j < gap; j++)
                tick(int'($urandom_range(0, MOD - 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bin_out"}, bin_out, 0);
        check({tag, "_bin_vld"}, bin_vld, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_step_err"}, step_err, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_wrap_cnt"}, wrap_cnt, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_zero("rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0; first_lock = -1;
        compare_all();
    endtask

    initial begin
        int p0, w0;
        rst = 1'b0; gray_in = '0; gray_vld = 1'b0; wrap_in = 1'b0; clr_err = 1'b0;
        cyc = 0; first_lock = -1; n_pulse = 0; cur = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Clean count 0..15 then into the next lap.
        cur = 0;
        feed(MOD + 2, 0);
        idle(2);
        check("lock_cycle", first_lock, 2 + LOCK_N + 1);
        check("wrap_after_lap", wrap_cnt, 1);
        check("no_err_clean", n_pulse, 0);

        // Skip from 3 to 5 while locked.
        while (cur != 3) feed(1, 0);
        p0 = n_pulse;
        feed(1, 0);
        tick(5, 1'b1, 1'b0, 1'b0);
        idle(3);
        check("skip_pulses", n_pulse - p0, 1);
        check("skip_fault", fault, 1);
        check("skip_locked", locked, 0);

        // Clear, relock from a random point, keep the wrap count.
        tick(0, 1'b0, 1'b0, 1'b1);
        check("clr_fault", fault, 0);
        cur = int'($urandom_range(0, MOD - 1));
        feed(LOCK_N + 1, 0);
        idle(2);
        check("relock", locked, 1);
        check("relock_wrap_held", wrap_cnt, 1);

        // Wrap pulse on the wrong sample.
        while (cur != 7) feed(1, 0);
        p0 = n_pulse;
        w0 = int'(wrap_cnt);
        tick(7, 1'b1, 1'b1, 1'b0);
        cur = 8;
        idle(3);
        check("badwrap_pulses", n_pulse - p0, 1);
        check("badwrap_fault", fault, 1);
        check("badwrap_cnt_held", wrap_cnt, w0);

        // Clear, relock, then gaps of three idle cycles between samples.
        tick(0, 1'b0, 1'b0, 1'b1);
        cur = int'($urandom_range(0, MOD - 1));
        feed(LOCK_N + 2, 0);
        feed(12, 3);
        check("gaps_locked", locked, 1);

        // Reset in the middle of traffic.
        feed(3, 0);
        do_reset();
        check("post_rst_locked", locked, 0);

        // Enough aligned laps to saturate the wrap counter.
        cur = 0;
        feed(5 * MOD + 2, 0);
        idle(2);
        check("wrap_saturated", wrap_cnt, WMAX);

        // Random traffic: gaps, skips, misplaced wraps and clears.
        for (int i = 0; i < 600; i++) begin
            int  r  = int'($urandom_range(0, 63));
            bit  v  = (r % 4) != 0;
            int  b  = cur;
            bit  w;
            if (r < 4) b = int'($urandom_range(0, MOD - 1));
            w = (b == MOD - 1);
            if (r >= 60) w = !w;
            if (r % 16 == 5) do_reset();
            tick(b, v, w, (r % 8) == 3);
            if (v) cur = (b + 1) % MOD;
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, limit 500000 expected finish");
        $fatal(1);
    end

endmodule
